// File: rtl/demux16_capture.sv
// 1-to-16 serial capture: steers one bit per accept into a 16-lane frame.
// Optional out_parity port enabled by defining DEMUX16_CAPTURE_PARITY_EN.
module demux16_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        din,
    input  logic [3:0]  sel,
    input  logic        auto_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef DEMUX16_CAPTURE_PARITY_EN
    ,
    output logic        out_parity
`endif
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_mask;
    logic [15:0] r_data;
    logic [3:0]  r_cnt;
`ifdef DEMUX16_CAPTURE_PARITY_EN
    logic        r_parity;
`endif

    logic        w_accept;
    logic [3:0]  w_idx;
    logic [15:0] w_lane;
    logic [15:0] w_mask_nxt;
    logic [15:0] w_data_nxt;

    assign w_accept   = in_valid && (r_state == FILL);
    assign w_idx      = auto_mode ? r_cnt : sel;
    assign w_lane     = 16'h0001 << w_idx;
    assign w_mask_nxt = r_mask | w_lane;
    assign w_data_nxt = (r_data & ~w_lane) | (din ? w_lane : 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_mask   <= 16'h0000;
            r_data   <= 16'h0000;
            r_cnt    <= 4'd0;
`ifdef DEMUX16_CAPTURE_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (clr) begin
            // Frame clear beats any simultaneous accept or handoff
            r_state  <= FILL;
            r_mask   <= 16'h0000;
            r_data   <= 16'h0000;
            r_cnt    <= 4'd0;
`ifdef DEMUX16_CAPTURE_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_data <= w_data_nxt;
                        r_mask <= w_mask_nxt;
                        if (auto_mode)
                            r_cnt <= r_cnt + 4'd1;
                        if (&w_mask_nxt) begin
                            r_state  <= HOLD;
`ifdef DEMUX16_CAPTURE_PARITY_EN
                            r_parity <= ^w_data_nxt;
`endif
                        end
                    end
                end
                HOLD: begin
                    // Data is kept; lanes get overwritten by the next frame
                    if (out_ready) begin
                        r_state <= FILL;
                        r_mask  <= 16'h0000;
                        r_cnt   <= 4'd0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == FILL);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_data;
`ifdef DEMUX16_CAPTURE_PARITY_EN
    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_demux16_capture.sv
// Randomised bench for demux16_capture with a lane-array reference model.
// Directed frames pin the model; a negedge process compares every cycle.
module tb_demux16_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic        din;
    logic [3:0]  sel;
    logic        auto_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef DEMUX16_CAPTURE_PARITY_EN
    logic        out_parity;
`endif

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    demux16_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .sel       (sel),
        .auto_mode (auto_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX16_CAPTURE_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-lane value and "written" flag, a lane pointer,
    // and a flag saying a full frame is being presented.
    bit m_val [16];
    bit m_wr  [16];
    int m_ptr;
    bit m_hold;
    bit m_par;

    function automatic logic [15:0] m_word();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[k] = m_val[k];
        return w;
    endfunction

    function automatic bit m_full();
        for (int k = 0; k < 16; k++) if (!m_wr[k]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            for (int k = 0; k < 16; k++) begin
                m_val[k] = 1'b0;
                m_wr[k]  = 1'b0;
            end
            m_ptr  = 0;
            m_hold = 1'b0;
            m_par  = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                for (int k = 0; k < 16; k++) m_wr[k] = 1'b0;
                m_ptr  = 0;
                m_hold = 1'b0;
            end
        end else if (in_valid) begin
            int lane;
            lane = auto_mode ? m_ptr : int'(sel);
            m_val[lane] = din;
            m_wr[lane]  = 1'b1;
            if (auto_mode) m_ptr = (m_ptr + 1) % 16;
            if (m_full()) begin
                m_hold = 1'b1;
                m_par  = ^m_word();
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", {15'd0, in_ready}, {15'd0, rst_n && !m_hold});
            chk("out_valid", {15'd0, out_valid}, {15'd0, m_hold});
            chk("out_data", out_data, m_word());
`ifdef DEMUX16_CAPTURE_PARITY_EN
            if (m_hold) chk("out_parity", {15'd0, out_parity}, {15'd0, m_par});
`endif
        end
    end

    // Drive one cycle of inputs, then wait to the next negedge.
    task automatic step(input bit v, input bit d, input logic [3:0] s,
                        input bit a, input bit r, input bit c);
        in_valid  = v;
        din       = d;
        sel       = s;
        auto_mode = a;
        out_ready = r;
        clr       = c;
        @(negedge clk);
    endtask

    task automatic handoff();
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("handoff_valid", {15'd0, out_valid}, 16'd0);
    endtask

    logic [15:0] saved;

    initial begin
        rst_n = 1'b0;
        clr = 0; in_valid = 0; din = 0; sel = 0; auto_mode = 0; out_ready = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {15'd0, in_ready}, 16'd1);
        cmp_en = 1'b1;

        // Auto frame, alternating bits starting with 1
        for (int i = 0; i < 16; i++) step(1, (i % 2) == 0, 4'd0, 1, 0, 0);
        chk("auto_valid", {15'd0, out_valid}, 16'd1);
        chk("auto_data", out_data, 16'h5555);
`ifdef DEMUX16_CAPTURE_PARITY_EN
        chk("auto_parity", {15'd0, out_parity}, 16'd0);
`endif
        handoff();

        // Addressed descending, only lane 3 set
        for (int i = 15; i >= 0; i--) step(1, i == 3, 4'(i), 0, 0, 0);
        chk("addr_valid", {15'd0, out_valid}, 16'd1);
        chk("addr_data", out_data, 16'h0008);
        handoff();

        // Lane 5 rewritten; completion needs 17 accepts
        step(1, 1, 4'd5, 0, 0, 0);
        step(1, 0, 4'd5, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            if (i == 14) chk("rewrite_pending", {15'd0, out_valid}, 16'd0);
            step(1, 1, (i < 5) ? 4'(i) : 4'(i + 1), 0, 0, 0);
        end
        chk("rewrite_valid", {15'd0, out_valid}, 16'd1);
        chk("rewrite_data", out_data, 16'hFFDF);

        // Stall in HOLD with in_valid high
        saved = out_data;
        for (int i = 0; i < 10; i++) begin
            step(1, 1'($urandom), 4'($urandom), 1, 0, 0);
            chk("stall_ready", {15'd0, in_ready}, 16'd0);
            chk("stall_data", out_data, saved);
        end
        handoff();
        chk("handoff_ready", {15'd0, in_ready}, 16'd1);

        // Clear coincident with the completing accept
        for (int i = 0; i < 15; i++) step(1, 1, 4'd0, 1, 0, 0);
        step(1, 1, 4'd0, 1, 0, 1);
        chk("clr_valid", {15'd0, out_valid}, 16'd0);
        chk("clr_data", out_data, 16'h0000);

        // Reset pulse mid-frame
        for (int i = 0; i < 8; i++) step(1, 1, 4'd0, 1, 0, 0);
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {15'd0, in_ready}, 16'd0);
        chk("midrst_data", out_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step(1, 1, 4'd0, 1, 0, 0);
        chk("midrst_pending", {15'd0, out_valid}, 16'd0);
        step(1, 1, 4'd0, 1, 0, 0);
        chk("midrst_valid", {15'd0, out_valid}, 16'd1);
        chk("midrst_full", out_data, 16'hFFFF);
        handoff();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
